// File: rtl/eager_fork_buffered.sv
// Registered eager fork: one-slot buffer that replicates each token to SIZE
// outputs, each output completing its handshake independently of the others.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   ins         input token data            [DATA_TYPE-1:0]
//   ins_valid   input token present
//   ins_ready   block accepts the input token this cycle
//   outs        replicated data, channel i at [i*DATA_TYPE +: DATA_TYPE]
//   outs_valid  per-channel valid           [SIZE-1:0]
//   outs_ready  per-channel ready           [SIZE-1:0]
module eager_fork_buffered #(
    parameter int DATA_TYPE = 32,
    parameter int SIZE      = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_TYPE-1:0]      ins,
    input  logic                      ins_valid,
    output logic                      ins_ready,
    output logic [SIZE*DATA_TYPE-1:0] outs,
    output logic [SIZE-1:0]           outs_valid,
    input  logic [SIZE-1:0]           outs_ready
);

    logic                 full_q, full_d;
    logic [DATA_TYPE-1:0] data_q, data_d;
    logic [SIZE-1:0]      sent_q, sent_d;

    logic [SIZE-1:0]      xfer;
    logic                 done;
    logic                 cap;

    always_comb begin
        outs_valid = {SIZE{full_q}} & ~sent_q;
        xfer       = outs_valid & outs_ready;
        // Token retires once every output has taken it or takes it now.
        done       = full_q & (&(sent_q | outs_ready));
        ins_ready  = ~full_q | done;
        cap        = ins_valid & ins_ready;

        full_d = full_q;
        data_d = data_q;
        sent_d = sent_q | xfer;

        if (done) begin
            sent_d = '0;
            full_d = 1'b0;
        end
        // A capture in the retiring cycle refills the slot with fresh flags.
        if (cap) begin
            full_d = 1'b1;
            data_d = ins;
        end
    end

    // Every channel carries the held data, valid or not.
    assign outs = {SIZE{data_q}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q <= 1'b0;
            data_q <= '0;
            sent_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            sent_q <= sent_d;
        end
    end

endmodule

// File: tb/tb_eager_fork_buffered.sv
// Testbench for eager_fork_buffered (SIZE=2, 8-bit tokens).
// Table-driven vectors plus sequences for reset and streaming.
module tb_eager_fork_buffered;

    localparam int W = 8;
    localparam int N = 2;

    logic           clk;
    logic           rst;
    logic [W-1:0]   ins;
    logic           ins_valid;
    logic           ins_ready;
    logic [N*W-1:0] outs;
    logic [N-1:0]   outs_valid;
    logic [N-1:0]   outs_ready;

    int total;
    int passed;

    eager_fork_buffered #(.DATA_TYPE(W), .SIZE(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs       (outs),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] din;
        logic         vin;
        logic [N-1:0] rdy;
        logic         exp_ir;
        logic [N-1:0] exp_ov;
        logic [W-1:0] exp_d;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic chk_state(input string tag, input logic ir,
                             input logic [N-1:0] ov, input logic [W-1:0] d);
        chk({tag, "_ir"}, 32'(ins_ready), 32'(ir));
        chk({tag, "_ov"}, 32'(outs_valid), 32'(ov));
        chk({tag, "_d"}, 32'(outs), 32'({d, d}));
    endtask

    initial begin
        total = 0;
        passed = 0;

        // Cycle contents: inputs, then expected ins_ready / outs_valid / data
        // observed in that cycle before the edge. State carries row to row.
        tbl[0]  = '{8'h12, 1'b1, 2'b00, 1'b1, 2'b00, 8'h00};
        tbl[1]  = '{8'h00, 1'b0, 2'b11, 1'b1, 2'b11, 8'h12};
        tbl[2]  = '{8'h00, 1'b0, 2'b11, 1'b1, 2'b00, 8'h12};
        tbl[3]  = '{8'h34, 1'b1, 2'b00, 1'b1, 2'b00, 8'h12};
        tbl[4]  = '{8'h00, 1'b0, 2'b01, 1'b0, 2'b11, 8'h34};
        tbl[5]  = '{8'h00, 1'b0, 2'b01, 1'b0, 2'b10, 8'h34};
        tbl[6]  = '{8'h99, 1'b1, 2'b01, 1'b0, 2'b10, 8'h34};
        tbl[7]  = '{8'h00, 1'b0, 2'b10, 1'b1, 2'b10, 8'h34};
        tbl[8]  = '{8'h00, 1'b0, 2'b11, 1'b1, 2'b00, 8'h34};
        tbl[9]  = '{8'h66, 1'b1, 2'b00, 1'b1, 2'b00, 8'h34};
        tbl[10] = '{8'h00, 1'b0, 2'b01, 1'b0, 2'b11, 8'h66};
        tbl[11] = '{8'h55, 1'b1, 2'b10, 1'b1, 2'b10, 8'h66};
        tbl[12] = '{8'h00, 1'b0, 2'b00, 1'b0, 2'b11, 8'h55};
        tbl[13] = '{8'h00, 1'b0, 2'b11, 1'b1, 2'b11, 8'h55};
        tbl[14] = '{8'h00, 1'b0, 2'b01, 1'b1, 2'b00, 8'h55};
        tbl[15] = '{8'h00, 1'b0, 2'b10, 1'b1, 2'b00, 8'h55};
        tbl[16] = '{8'h77, 1'b1, 2'b10, 1'b1, 2'b00, 8'h55};
        tbl[17] = '{8'h00, 1'b0, 2'b10, 1'b0, 2'b11, 8'h77};
        tbl[18] = '{8'h00, 1'b0, 2'b10, 1'b0, 2'b01, 8'h77};
        tbl[19] = '{8'h00, 1'b0, 2'b01, 1'b1, 2'b01, 8'h77};
        tbl[20] = '{8'h00, 1'b0, 2'b00, 1'b1, 2'b00, 8'h77};

        // Reset with a token offered: nothing may be captured.
        rst = 1'b0;
        ins = 8'hA5;
        ins_valid = 1'b1;
        outs_ready = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk_state("rst_hold", 1'b1, 2'b00, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_state("rst_rel", 1'b1, 2'b00, 8'h00);
        ins_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_state("rst_idle", 1'b1, 2'b00, 8'h00);

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            ins = tbl[i].din;
            ins_valid = tbl[i].vin;
            outs_ready = tbl[i].rdy;
            #1;
            chk_state($sformatf("v%0d", i), tbl[i].exp_ir,
                      tbl[i].exp_ov, tbl[i].exp_d);
        end

        // Back-to-back streaming of tokens 1..8 with both outputs ready.
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            ins = 8'(i);
            ins_valid = (i <= 8);
            outs_ready = 2'b11;
            #1;
            chk($sformatf("stream%0d_ir", i), 32'(ins_ready), 32'd1);
            if (i >= 2) begin
                chk($sformatf("stream%0d_ov", i), 32'(outs_valid), 32'h3);
                chk($sformatf("stream%0d_d", i), 32'(outs),
                    32'({8'(i - 1), 8'(i - 1)}));
            end
        end
        @(negedge clk);
        ins_valid = 1'b0;
        #1;
        chk("stream_end_ov", 32'(outs_valid), 32'h0);

        // Mid-operation reset with sent=01.
        @(negedge clk);
        ins = 8'h88;
        ins_valid = 1'b1;
        outs_ready = 2'b00;
        @(negedge clk);
        ins_valid = 1'b0;
        outs_ready = 2'b01;
        #1;
        chk_state("mr_load", 1'b0, 2'b11, 8'h88);
        @(negedge clk);
        outs_ready = 2'b00;
        #1;
        chk_state("mr_sent", 1'b0, 2'b10, 8'h88);
        #2;
        rst = 1'b0;
        #1;
        chk_state("mr_async", 1'b1, 2'b00, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        outs_ready = 2'b11;
        #1;
        chk_state("mr_rel", 1'b1, 2'b00, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        chk_state("mr_stale", 1'b1, 2'b00, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/eager_fork_buffered.md
# eager_fork_buffered

Registered eager fork for the dataflow library, the dual of the two-input join used by operators such as `cmpi`. It accepts one token on a valid/ready input channel and holds it in a one-slot register stage. It then replicates the token to `SIZE` output channels, letting each output complete its handshake independently. It sits after any single-result operator whose result feeds several consumers, and it breaks the combinational valid path between producer and consumers.

## Interface
Parameters:
- `DATA_TYPE`, 32: token width in bits (≥1).
- `SIZE`, 2: number of output channels (≥2).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (state cleared while `rst`=0).
- `ins`  in  DATA_TYPE  input token data.
- `ins_valid`  in  1  input token present.
- `ins_ready`  out  1  block accepts the input token this cycle.
- `outs`  out  SIZE*DATA_TYPE  replicated data; channel i occupies bits [i*DATA_TYPE +: DATA_TYPE].
- `outs_valid`  out  SIZE  per-channel valid.
- `outs_ready`  in  SIZE  per-channel ready.

## Operation
- State:
  - `full` (1 bit): slot holds a token.
  - `data` (DATA_TYPE bits): held token.
  - `sent[SIZE-1:0]`: per-output flags; bit i means output i has already taken the held token.
- Outputs:
  - `outs_valid[i] = full & ~sent[i]`.
  - Every channel of `outs` = `data` at all times, including while that channel is not valid.
- Per-output transfer: `xfer[i] = outs_valid[i] & outs_ready[i]`.
- Token completion: `done = full & AND_i(sent[i] | outs_ready[i])`. The token is consumed when every output has either already taken it or takes it this cycle.
- Input acceptance:
  - `ins_ready = ~full | done`.
  - Capture when `ins_valid & ins_ready`: `data <= ins`, `full <= 1`.
- Update of `sent` (priority order):
  - If `done`: `sent <= 0`, independent of a simultaneous capture.
  - Else: `sent[i] <= sent[i] | xfer[i]`.
- `full` update:
  - Capture: `full <= 1`.
  - `done` without capture: `full <= 0`.
  - Otherwise: hold.
- Eager semantics:
  - A ready output never waits for a stalled sibling.
  - Each output receives each token exactly once, in input order.
  - Tokens are never dropped or duplicated.
- Combinational paths:
  - `outs_ready` → `ins_ready`: allowed; this path is what gives full throughput.
  - `ins_valid`/`ins` → `outs_valid`/`outs`: none; both are driven from registers only.

## Timing
- Reset (`rst`=0, asynchronous):
  - State: `full`=0, `sent`=0, `data`=0.
  - Outputs: `outs_valid`=0, `outs`=0, `ins_ready`=1.
  - No capture while `rst`=0, even if `ins_valid`=1.
- Reset asserted mid-operation:
  - The held token and all `sent` flags are discarded immediately.
  - `outs_valid` drops to 0 without waiting for a clock edge.
- Latency: a token accepted at edge N gives `outs_valid`=all ones in the cycle after edge N.
- Throughput: with `outs_ready` all ones, one token per cycle sustained. `done` and capture coincide, so `full` stays 1.
- Partial readiness:
  - Outputs that are ready take the token; their `sent` bits set at the edge and their `outs_valid` bits drop.
  - Remaining outputs stay valid until they accept.
  - `ins_ready`=0 until the last pending output is ready.
- Last-output cycle: when the final pending output accepts, `done`=1 in that same cycle. A new token may be captured at that edge, and `sent` clears to 0 at the same edge.
- Empty: `outs_valid`=0 and `ins_ready`=1, regardless of `outs_ready`.
- `outs_ready` may toggle freely while an output is not valid; this has no effect on state.

## Test plan
- Reset then idle, `SIZE`=2:
  - Response: `outs_valid`=00, `ins_ready`=1.
  - Driving `ins_valid`=1, `ins`=0xA5 while `rst`=0 → still empty after `rst` rises.
- Single token, both outputs ready:
  - Stimulus: `ins`=0x12 accepted at edge 1.
  - Response: cycle 2 `outs_valid`=11, both `outs` = 0x12. After edge 2, `outs_valid`=00.
- Eager split:
  - Stimulus: token 0x34 held; `outs_ready`=01 for 3 cycles, then 10.
  - Response:
    - Out0 takes the token in the first cycle; `outs_valid`=10 thereafter.
    - `ins_ready`=0 throughout the wait.
    - When `outs_ready`=10, `done`=1 and `ins_ready`=1.
    - Each output sees 0x34 exactly once.
- Back-to-back streaming:
  - Stimulus: tokens 1..8 on consecutive cycles with `outs_ready`=11.
  - Response: `ins_ready` stays 1; each output sees 1..8 on consecutive cycles.
- Last-output capture:
  - Stimulus: out1 pending with `sent`=01; assert `outs_ready`=10 and present token 0x55 in the same cycle.
  - Response: 0x55 is captured; next cycle `outs_valid`=11 with data 0x55.
- Mid-operation reset:
  - Stimulus: token held with `sent`=01; pulse `rst`=0 between clock edges.
  - Response: `outs_valid` goes to 00 immediately. After release, `ins_ready`=1 and no stale token reappears.
